// File: rtl/sd_dat_writer.sv
// sd_dat_writer
//   Sends one 512-byte sector to an SD card over DAT0 (1-bit bus) and then
//   collects the card's CRC-status token and its busy indication.
//   On the wire: NWR idle-high bits, a start bit, 4096 data bits (byte 0
//   first, MSB first), CRC16 (MSB first) and an end bit. The host then
//   releases DAT0, waits for the 3-bit status token and waits for busy to end.
//   Everything runs on clk. The host changes DAT0 on sdclk falling edges and
//   samples DAT0 on sdclk rising edges. Edges are found with one registered
//   copy of sdclk.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   sdclk             SD clock from the command controller (sampled on clk)
//   sddat0_in         DAT0 as seen at the pad
//   sddat0_oe/_out    DAT0 output enable (1 = drive) and drive value
//   wstart            one-clk pulse that starts a sector write
//   wbusy             high from the clk after wstart until wdone
//   wdone             one-clk pulse at the end of the transfer
//   werr              00 ok, 01 CRC rejected, 10 write error, 11 timeout
//   inreq/inaddr      one-clk request for sector byte inaddr
//   inbyte            requested byte, valid one clk after inreq
module sd_dat_writer #(
  parameter int NWR         = 2,
  parameter int STATTIMEOUT = 64,
  parameter int BUSYTIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdclk,
  input  logic       sddat0_in,
  output logic       sddat0_oe,
  output logic       sddat0_out,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [1:0] werr,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte
);

  // One counter serves for bits, status bits and timeouts, so it must be
  // wide enough for the largest of them.
  localparam int MAXA = (BUSYTIMEOUT > STATTIMEOUT) ? BUSYTIMEOUT : STATTIMEOUT;
  localparam int MAXB = (MAXA > NWR) ? MAXA : NWR;
  localparam int MAXC = (MAXB > 4096) ? MAXB : 4096;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END,
    S_STATWAIT, S_STATUS, S_BUSY, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic            r_sdclk_q;
  logic            r_oe, r_out;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_crc;
  logic [7:0]      r_shift, r_stage;
  logic [1:0]      r_stat;
  logic            r_req_d;
  logic [1:0]      r_werr;
  logic            r_wbusy;
  logic            r_inreq;
  logic [8:0]      r_inaddr;

  logic            w_fall, w_rise, w_first, w_dbit;
  logic [CW-1:0]   w_cnt_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // CRC16-CCITT (x^16+x^12+x^5+1), one data bit per call.
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign w_fall    = r_sdclk_q & ~sdclk;
  assign w_rise    = ~r_sdclk_q & sdclk;
  assign w_cnt_inc = sat_inc(r_cnt);
  // Bit 7 of each byte comes from the staging register. Later bits come from the shifter.
  assign w_first   = (r_cnt[2:0] == 3'd0);
  assign w_dbit    = w_first ? r_stage[7] : r_shift[7];

  assign sddat0_oe  = r_oe;
  assign sddat0_out = r_out;
  assign wbusy      = r_wbusy;
  assign wdone      = (r_state == S_DONE);
  assign werr       = r_werr;
  assign inreq      = r_inreq;
  assign inaddr     = r_inaddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (wstart) w_next = S_PRE;
      S_PRE:      if (w_fall && r_cnt == CW'(NWR - 1)) w_next = S_START;
      S_START:    if (w_fall) w_next = S_DATA;
      S_DATA:     if (w_fall && r_cnt == CW'(4095)) w_next = S_CRC;
      S_CRC:      if (w_fall && r_cnt == CW'(15)) w_next = S_END;
      S_END:      if (w_fall && r_cnt == CW'(1)) w_next = S_STATWAIT;
      S_STATWAIT: if (w_rise) begin
                    if (!sddat0_in)                          w_next = S_STATUS;
                    else if (w_cnt_inc >= CW'(STATTIMEOUT))  w_next = S_DONE;
                  end
      S_STATUS:   if (w_rise && r_cnt == CW'(2)) w_next = S_BUSY;
      S_BUSY:     if (w_rise && (sddat0_in || w_cnt_inc >= CW'(BUSYTIMEOUT)))
                    w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // control / bus drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdclk_q <= 1'b0;
      r_oe      <= 1'b0;
      r_out     <= 1'b1;
      r_cnt     <= '0;
      r_crc     <= 16'h0000;
      r_req_d   <= 1'b0;
      r_werr    <= 2'b00;
      r_wbusy   <= 1'b0;
      r_inreq   <= 1'b0;
      r_inaddr  <= 9'd0;
    end else begin
      r_sdclk_q <= sdclk;
      r_inreq   <= 1'b0;
      r_inaddr  <= 9'd0;
      r_req_d   <= r_inreq;

      // The counter restarts on every state change. Otherwise it counts the
      // edge that matters in the current state.
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((w_fall && (r_state inside {S_PRE, S_DATA, S_CRC, S_END})) ||
               (w_rise && (r_state inside {S_STATWAIT, S_STATUS, S_BUSY})))
        r_cnt <= w_cnt_inc;

      case (r_state)
        S_IDLE: if (wstart) begin
          r_werr   <= 2'b00;
          r_wbusy  <= 1'b1;
          r_crc    <= 16'h0000;
          r_inreq  <= 1'b1;
          r_inaddr <= 9'd0;
        end
        S_PRE: if (w_fall) begin
          r_oe  <= 1'b1;
          r_out <= 1'b1;
        end
        S_START: if (w_fall) r_out <= 1'b0;
        S_DATA: if (w_fall) begin
          r_out <= w_dbit;
          r_crc <= crc_next(r_crc, w_dbit);
          // Fetch the next byte while this one is on the wire.
          if (w_first && r_cnt[11:3] != 9'd511) begin
            r_inreq  <= 1'b1;
            r_inaddr <= r_cnt[11:3] + 9'd1;
          end
        end
        S_CRC: if (w_fall) begin
          r_out <= r_crc[15];
          r_crc <= {r_crc[14:0], 1'b0};
        end
        S_END: if (w_fall) begin
          r_out <= 1'b1;
          if (r_cnt != '0) r_oe <= 1'b0;
        end
        S_STATWAIT: if (w_rise && sddat0_in && w_next == S_DONE) r_werr <= 2'b11;
        S_STATUS: if (w_rise && r_cnt == CW'(2)) begin
          case ({r_stat, sddat0_in})
            3'b010:  r_werr <= r_werr;
            3'b101:  r_werr <= 2'b01;
            default: r_werr <= 2'b10;
          endcase
        end
        // A busy timeout overrides any code set by the status token.
        S_BUSY: if (w_rise && !sddat0_in && w_next == S_DONE) r_werr <= 2'b11;
        S_DONE: r_wbusy <= 1'b0;
        default: ;
      endcase
    end
  end

  // data path: byte staging, serialiser, status shift
  always_ff @(posedge clk) begin
    if (r_req_d) r_stage <= inbyte;
    if (r_state == S_DATA && w_fall)
      r_shift <= w_first ? {r_stage[6:0], 1'b0} : {r_shift[6:0], 1'b0};
    if (r_state == S_STATUS && w_rise)
      r_stat <= {r_stat[0], sddat0_in};
  end

endmodule

// File: tb/tb_sd_dat_writer.sv
module tb_sd_dat_writer;
  localparam int NWR   = 2;
  localparam int STO   = 20;
  localparam int BTO   = 40;
  localparam int NBITS = NWR + 1 + 4096 + 16 + 1;

  logic       clk = 1'b0, rst = 1'b1, sdclk = 1'b0;
  logic       sddat0_in, sddat0_oe, sddat0_out;
  logic       wstart = 1'b0, wbusy, wdone, inreq;
  logic [1:0] werr;
  logic [8:0] inaddr;
  logic [7:0] inbyte = 8'h00;
  logic       card_drv = 1'b1;

  assign sddat0_in = sddat0_oe ? sddat0_out : card_drv;

  sd_dat_writer #(.NWR(NWR), .STATTIMEOUT(STO), .BUSYTIMEOUT(BTO)) dut (
    .clk(clk), .rst(rst), .sdclk(sdclk), .sddat0_in(sddat0_in),
    .sddat0_oe(sddat0_oe), .sddat0_out(sddat0_out), .wstart(wstart),
    .wbusy(wbusy), .wdone(wdone), .werr(werr), .inreq(inreq),
    .inaddr(inaddr), .inbyte(inbyte)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (2) @(posedge clk);
      #1 sdclk = ~sdclk;
    end
  end

  int         n_tests = 0, n_fail = 0;
  logic [7:0] sector [512];
  bit         host_q[$], exp_q[$], resp_q[$];
  int         req_q[$];
  int         wdone_cnt = 0, rise_cnt = 0, rise_at_done = 0, addr_bad = 0;
  logic [1:0] werr_done = 2'b00;
  bit         pend_vld = 1'b0;
  logic [8:0] pend_addr = 9'd0;

  // Card side: collect host bits on rising edges, change response on falling edges.
  always @(posedge sdclk) begin
    rise_cnt++;
    if (sddat0_oe) host_q.push_back(sddat0_out);
  end

  always @(negedge sdclk) begin
    if (resp_q.size() > 0) card_drv = resp_q.pop_front();
    else                   card_drv = 1'b1;
  end

  // Sector memory: byte valid only in the clk following its request.
  always @(negedge clk) begin
    inbyte = pend_vld ? sector[pend_addr] : 8'($urandom);
    pend_vld  = inreq;
    pend_addr = inaddr;
    if (inreq) req_q.push_back(int'(inaddr));
    else if (inaddr != 9'd0) addr_bad++;
    if (wdone) begin
      wdone_cnt++;
      werr_done    = werr;
      rise_at_done = rise_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 512; k++)
      case (mode)
        0:       sector[k] = 8'h00;
        1:       sector[k] = 8'hFF;
        2:       sector[k] = 8'(k % 256);
        default: sector[k] = 8'($urandom);
      endcase
  endtask

  // Reference stream built from the line format: preamble, start, data, CRC, end.
  task automatic build_expected();
    logic [15:0] c = 16'h0000;
    exp_q.delete();
    repeat (NWR) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int k = 0; k < 512; k++)
      for (int b = 7; b >= 0; b--) begin
        exp_q.push_back(sector[k][b]);
        c = (c[15] ^ sector[k][b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic pulse_wstart();
    @(posedge clk); #1 wstart = 1'b1;
    @(posedge clk); #1 wstart = 1'b0;
  endtask

  function automatic logic [15:0] sent_crc();
    logic [15:0] c = 16'h0;
    for (int i = 0; i < 16; i++)
      if (NWR + 1 + 4096 + i < host_q.size()) c = {c[14:0], host_q[NWR + 1 + 4096 + i]};
    return c;
  endfunction

  // kind: 0 = token then short busy, 1 = card silent, 2 = busy never ends
  task automatic run_xfer(input string nm, input int mode, input int kind,
                          input logic [2:0] tok, input int d, input int b,
                          input logic [1:0] exp_err, input bit dup);
    bit ok;
    int rel, mism, bad, n, exp_rises;
    fill(mode);
    build_expected();
    host_q.delete(); req_q.delete(); resp_q.delete();
    wdone_cnt = 0; addr_bad = 0;
    pulse_wstart();
    check({nm, "/wbusy_start"}, wbusy, 1'b1);
    if (dup) begin
      for (int c = 0; c < 5000 && host_q.size() < 300; c++) @(posedge clk);
      pulse_wstart();
    end
    ok = 1'b0;
    for (int c = 0; c < 25000; c++) begin
      @(posedge clk); #1;
      if (host_q.size() >= NBITS && !sddat0_oe) begin ok = 1'b1; break; end
    end
    check({nm, "/release"}, ok, 1'b1);
    rel = rise_cnt;
    if (kind != 1) begin
      repeat (d) resp_q.push_back(1'b1);
      resp_q.push_back(1'b0);
      resp_q.push_back(tok[2]); resp_q.push_back(tok[1]); resp_q.push_back(tok[0]);
      repeat ((kind == 2) ? BTO + 20 : b) resp_q.push_back(1'b0);
      resp_q.push_back(1'b1);
    end
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (wdone_cnt > 0) begin ok = 1'b1; break; end
    end
    check({nm, "/done_seen"}, ok, 1'b1);
    repeat (4) @(posedge clk); #1;
    check({nm, "/wdone_count"}, wdone_cnt, 1);
    check({nm, "/werr_at_done"}, werr_done, exp_err);
    check({nm, "/werr_held"}, werr, exp_err);
    check({nm, "/wbusy_end"}, wbusy, 1'b0);
    exp_rises = (kind == 1) ? STO : (kind == 2) ? (d + BTO + 5) : (d + b + 6);
    check({nm, "/status_edges"}, rise_at_done - rel, exp_rises);
    check({nm, "/stream_len"}, host_q.size(), exp_q.size());
    n = (host_q.size() < exp_q.size()) ? host_q.size() : exp_q.size();
    mism = 0;
    for (int i = 0; i < n; i++) if (host_q[i] != exp_q[i]) mism++;
    check({nm, "/stream_bits"}, mism, 0);
    check({nm, "/req_count"}, req_q.size(), 512);
    bad = 0;
    for (int i = 0; i < req_q.size(); i++) if (req_q[i] != i) bad++;
    check({nm, "/req_order"}, bad, 0);
    check({nm, "/inaddr_idle"}, addr_bad, 0);
  endtask

  initial begin
    int d, b;
    rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("reset/oe", sddat0_oe, 1'b0);
    check("reset/out", sddat0_out, 1'b1);
    check("reset/wbusy", wbusy, 1'b0);
    check("reset/wdone", wdone, 1'b0);
    check("reset/werr", werr, 2'b00);
    check("reset/inreq", inreq, 1'b0);
    check("reset/inaddr", inaddr, 9'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // all zeros, accepted token, 10 busy edges, extra wstart mid-transfer
    run_xfer("zeros", 0, 0, 3'b010, $urandom_range(0, 5), 10, 2'b00, 1'b1);
    check("zeros/crc", sent_crc(), 16'h0000);

    // all ones, card never answers
    run_xfer("ones", 1, 1, 3'b010, 0, 0, 2'b11, 1'b0);
    check("ones/crc", sent_crc(), 16'h7FA1);

    // incrementing bytes, CRC rejected
    d = $urandom_range(0, 5); b = $urandom_range(1, 15);
    run_xfer("incr", 2, 0, 3'b101, d, b, 2'b01, 1'b0);

    // reset at data bit 2000
    fill(3);
    host_q.delete(); wdone_cnt = 0;
    pulse_wstart();
    for (int c = 0; c < 20000 && host_q.size() < NWR + 1 + 2000; c++) @(posedge clk);
    check("rst_mid/reached", host_q.size() >= NWR + 1 + 2000, 1'b1);
    check("rst_mid/oe_before", sddat0_oe, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid/oe", sddat0_oe, 1'b0);
    check("rst_mid/wbusy", wbusy, 1'b0);
    check("rst_mid/wdone", wdone, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("rst_mid/no_wdone", wdone_cnt, 0);
    check("rst_mid/oe_after", sddat0_oe, 1'b0);
    check("rst_mid/werr", werr, 2'b00);

    // random sector after reset, accepted token, busy never ends
    run_xfer("busy_to", 3, 2, 3'b010, $urandom_range(0, 5), 0, 2'b11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_dat_writer.md
SD_DAT_WRITER -- requirements
Module: sd_dat_writer

Interface
REQ-001 SHALL have parameter NWR, default 2, idle-high sdclk cycles driven before the start bit (min 2).
REQ-002 SHALL have parameter STATTIMEOUT, default 64, max sdclk rising edges waited for the CRC-status start bit.
REQ-003 SHALL have parameter BUSYTIMEOUT, default 1000000, max sdclk rising edges waited for DAT0 busy release.
REQ-004 clk  input  1  system clock, 0~50MHz; sole clock, all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sdclk  input  1  SD clock from command controller; each phase held >=2 clk cycles.
REQ-007 sddat0_in  input  1  DAT0 as seen from the card pad.
REQ-008 sddat0_oe  output  1  DAT0 output enable (1 = drive).
REQ-009 sddat0_out  output  1  DAT0 drive value.
REQ-010 wstart  input  1  one-clk pulse starting a sector transfer; asserted only after CMD24 response is accepted.
REQ-011 wbusy  output  1  high from the clk after an accepted wstart until wdone.
REQ-012 wdone  output  1  one-clk pulse, transfer finished; werr valid the same cycle.
REQ-013 werr  output  2  00 accepted, 01 CRC rejected, 10 write error, 11 timeout; held until next wstart.
REQ-014 inreq  output  1  one-clk pulse requesting sector byte inaddr.
REQ-015 inaddr  output  9  byte index 0..511; 0 when inreq low.
REQ-016 inbyte  input  8  requested byte, valid exactly one clk after inreq.

Function
REQ-017 SHALL detect sdclk falling edge (prev 1, now 0) and rising edge (prev 0, now 1) with one registered copy of sdclk.
REQ-018 SHALL change sddat0_oe/sddat0_out only on the clk of a detected falling edge; SHALL sample sddat0_in only on a detected rising edge.
REQ-019 States: IDLE, PRE, START, DATA, CRC, END, STATWAIT, STATUS, BUSY, DONE.
REQ-020 IDLE: oe=0; wstart -> PRE, ridx=0, werr=00, inreq for byte 0 on that clk; wstart while wbusy SHALL be ignored.
REQ-021 PRE: drive 1 for NWR falling edges, then START.
REQ-022 START: drive 0 for one sdclk period, then DATA.
REQ-023 DATA: 4096 bits, byte 0 first, each byte MSB first; bit counter 0..4095.
REQ-024 Byte prefetch: on the falling edge driving bit 7 of byte k (k<511), pulse inreq with inaddr=k+1; latch inbyte one clk later into a staging register; load staging at the bit-7 edge of byte k+1.
REQ-025 CRC16 poly x^16+x^12+x^5+1, init 0x0000, over the 4096 data bits only; CRC: 16 bits MSB first.
REQ-026 END: drive 1 for one period, then oe=0 at next falling edge and enter STATWAIT.
REQ-027 STATWAIT: first rising edge with sddat0_in=0 -> STATUS; after STATTIMEOUT edges -> DONE, werr=11.
REQ-028 STATUS: capture 3 bits; 010 -> BUSY; 101 -> werr=01, BUSY; any other -> werr=10, BUSY.
REQ-029 BUSY: first rising edge with sddat0_in=1 -> DONE; after BUSYTIMEOUT edges -> DONE, werr=11 (overrides earlier code).
REQ-030 DONE: pulse wdone one clk, return to IDLE; wbusy low the clk after wdone.
REQ-031 Bit and timeout counters SHALL saturate, never wrap; counts from wstart to wdone are exact (no extra/missing bits).
REQ-032 If sdclk stops, SHALL hold state indefinitely (timeouts count sdclk edges, not clk).

Reset
REQ-033 rst asserted: state IDLE, oe=0, out=1, wbusy=0, wdone=0, werr=00, inreq=0, inaddr=0, CRC=0, counters 0, immediately and asynchronously.
REQ-034 rst mid-transfer SHALL abort with no wdone pulse and release DAT0 within the same reset assertion.

Verification
REQ-035 All-0x00 sector, token 010, busy 10 edges -> 1 start bit, 4096 zeros, CRC 0x0000, end 1, werr=00, one wdone.
REQ-036 All-0xFF sector -> transmitted CRC 0x7FA1; inreq issued exactly 512 times, inaddr 0..511 in order.
REQ-037 Incrementing-byte sector (byte k = k mod 256), token 101 -> DAT0 bitstream matches model byte-for-byte, werr=01.
REQ-038 DAT0 held high after END -> STATTIMEOUT edges later wdone with werr=11; DAT0 held low after token 010 -> werr=11 after BUSYTIMEOUT.
REQ-039 rst pulsed during DATA at bit 2000 -> oe=0, wbusy=0, no wdone; next wstart completes normally with werr=00.
REQ-040 wstart repeated during transfer -> ignored, single wdone, bitstream unchanged.
